// File: rtl/absorb_feeder_if.sv
// Message word stream into the absorb feeder: valid/ready handshake plus tail
// byte count and message domain.
interface absorb_feeder_if #(
    parameter int BWIDTH = 32,
    parameter int DWIDTH = 2
) ();
    logic [BWIDTH-1:0] din;
    logic              din_valid;
    logic              din_last;
    logic [2:0]        din_nbytes;
    logic              din_ready;
    logic [DWIDTH-1:0] domain_in;

    modport master (
        output din, din_valid, din_last, din_nbytes, domain_in,
        input  din_ready
    );

    modport slave (
        input  din, din_valid, din_last, din_nbytes, domain_in,
        output din_ready
    );
endinterface

// File: rtl/absorb_feeder.sv
// Packs 32-bit message words into a block buffer, applies 10* byte padding and
// sequences the absorb block. Optional byte counter: ABSORB_FEEDER_BYTECOUNT_EN.
//
// state | meaning
// FILL  | accepting words into the block buffer
// ISSUE | restart pulse to the absorb block
// START | enable pulse to the absorb block
// WAIT  | block held stable until absorb_done
module absorb_feeder #(
    parameter int BWIDTH    = 32,
    parameter int NUMBLOCKS = 4,
    parameter int DWIDTH    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    absorb_feeder_if.slave              s_in,
    output logic [BWIDTH*NUMBLOCKS-1:0] blocks,
    output logic                        finalize,
    output logic [DWIDTH-1:0]           domain,
    output logic                        padded,
    output logic                        absorb_reset,
    output logic                        absorb_en,
    input  logic                        absorb_done,
    output logic                        msg_done
`ifdef ABSORB_FEEDER_BYTECOUNT_EN
    ,
    output logic [31:0]                 msg_bytes
`endif
);

    localparam int WCW = (NUMBLOCKS > 1) ? $clog2(NUMBLOCKS) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(NUMBLOCKS - 1);

    typedef enum logic [1:0] {FILL, ISSUE, START, WAIT} state_t;

    state_t                        state, state_next;
    logic [BWIDTH*NUMBLOCKS-1:0]   buffer, buf_next;
    logic [WCW-1:0]                wcnt;
    logic                          msg_active;
    logic                          accept;
    logic [2:0]                    nbytes_eff;
    logic [BWIDTH-1:0]             tail_word;

    assign accept = s_in.din_valid && (state == FILL);
    // Out-of-range byte counts behave as a full word.
    assign nbytes_eff = (s_in.din_nbytes > 3'd4) ? 3'd4 : s_in.din_nbytes;
    assign blocks = buffer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        s_in.din_ready = 1'b0;
        absorb_reset   = 1'b0;
        absorb_en      = 1'b0;
        case (state)
            FILL: begin
                s_in.din_ready = 1'b1;
                if (s_in.din_valid && (s_in.din_last || wcnt == WLAST)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                absorb_reset = 1'b1;
                state_next   = START;
            end
            START: begin
                absorb_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (absorb_done) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        tail_word = '0;
        for (int b = 0; b < BWIDTH / 8; b++) begin
            if (3'(b) < nbytes_eff) begin
                tail_word[b*8 +: 8] = s_in.din[b*8 +: 8];
            end else if (3'(b) == nbytes_eff) begin
                tail_word[b*8 +: 8] = 8'h01;
            end
        end
    end

    // Slots beyond the tail are zeroed; a full tail word pushes the pad byte into the next slot.
    always_comb begin
        buf_next = buffer;
        for (int k = 0; k < NUMBLOCKS; k++) begin
            if (k == int'(wcnt)) begin
                buf_next[k*BWIDTH +: BWIDTH] = s_in.din_last ? tail_word : s_in.din;
            end else if (s_in.din_last && k > int'(wcnt)) begin
                if (k == int'(wcnt) + 1 && nbytes_eff == 3'd4) begin
                    buf_next[k*BWIDTH +: BWIDTH] = BWIDTH'(1);
                end else begin
                    buf_next[k*BWIDTH +: BWIDTH] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer     <= '0;
            wcnt       <= '0;
            msg_active <= 1'b0;
            finalize   <= 1'b0;
            padded     <= 1'b0;
            domain     <= '0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        buffer <= buf_next;
                        if (!msg_active) begin
                            domain     <= s_in.domain_in;
                            msg_active <= 1'b1;
                        end
                        if (s_in.din_last) begin
                            finalize <= 1'b1;
                            padded   <= (nbytes_eff != 3'd4) || (wcnt != WLAST);
                        end else if (wcnt == WLAST) begin
                            finalize <= 1'b0;
                            padded   <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (absorb_done) begin
                        buffer <= '0;
                        wcnt   <= '0;
                        if (finalize) begin
                            msg_done   <= 1'b1;
                            msg_active <= 1'b0;
                            finalize   <= 1'b0;
                            padded     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ABSORB_FEEDER_BYTECOUNT_EN
    logic [31:0] byte_cnt;
    logic [32:0] byte_sum;

    always_comb begin
        byte_sum = {1'b0, (msg_active ? byte_cnt : 32'd0)}
                 + 33'(s_in.din_last ? nbytes_eff : 3'd4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
        end
    end

    assign msg_bytes = byte_cnt;
`endif

endmodule
